fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of i_cache. Owns the PC, issues one fetch
//  at a time on the i_cache CPU-side port, and buffers returned {pc,instr} pairs in a
//  small FIFO toward decode (valid/ready). Handles branch redirects, including a
//  redirect that lands while an i_cache miss is still outstanding.
// PARAMETERS
//  ADDR_WIDTH  32         PC / i_cache address width
//  DATA_WIDTH  32         instruction width
//  FIFO_DEPTH  4          instruction buffer entries (power of 2, >=2)
//  RESET_PC    32'h0      PC loaded at reset
//  PC_STEP     4          sequential PC increment, bytes
// PORTS
//  clk             in   1           clock, all state on posedge
//  rst_n           in   1           asynchronous active-low reset
//  fetch_en        in   1           1 = new fetches may be issued
//  redirect_valid  in   1           1-cycle pulse: load redirect_pc, flush
//  redirect_pc     in   ADDR_WIDTH  redirect target; bits[1:0] forced to 0
//  ic_addr         out  ADDR_WIDTH  to i_cache cpu_addr (registered)
//  ic_rd           out  1           to i_cache cpu_rd (registered)
//  ic_rdata        in   DATA_WIDTH  from i_cache cpu_rdata
//  ic_ready        in   1           from i_cache cpu_ready, 1-cycle pulse
//  if_valid        out  1           FIFO head valid toward decode
//  if_pc           out  ADDR_WIDTH  PC of head entry
//  if_instr        out  DATA_WIDTH  instruction of head entry
//  if_ready        in   1           decode accepts head when if_valid & if_ready
//  fetch_busy      out  1           1 while a request is in flight (REQ/WAIT/KILL)
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, ic_addr=RESET_PC, ic_rd=0, FIFO empty,
//   if_valid=0, if_pc=0, if_instr=0, fetch_busy=0. Reset mid-miss drops everything.
//  i_cache rules: at most one request outstanding; ic_rd high exactly one cycle per
//   request; ic_addr held stable from REQ until the matching ic_ready (i_cache
//   indexes its fill with the live address).
//  FSM:
//   IDLE: if fetch_en & cnt_next<FIFO_DEPTH & !redirect_valid -> REQ, ic_addr<=pc, ic_rd<=1.
//   REQ : ic_rd<=0 -> WAIT; if redirect_valid -> KILL (request already sampled).
//   WAIT: ic_ready & !redirect_valid: push {ic_addr,ic_rdata}, pc<=ic_addr+PC_STEP;
//         then if fetch_en & space -> REQ (ic_addr<=pc next, ic_rd<=1) else IDLE.
//         redirect_valid & !ic_ready -> KILL. redirect_valid & ic_ready -> drop data, IDLE.
//   KILL: ic_addr held, ic_rd=0; on ic_ready discard data -> IDLE.
//  Redirect (any state): pc<={redirect_pc[ADDR_WIDTH-1:2],2'b0}; FIFO flushed same
//   edge (same-cycle pop and push both void); later redirect in KILL overwrites pc.
//  Issue gate: cnt_next = cnt - pop + push; issue only if cnt_next<FIFO_DEPTH, so
//   the returning response always has a free slot (no overflow path).
//  FIFO: circular, log2(FIFO_DEPTH)-bit pointers wrap; count 0..FIFO_DEPTH.
//   if_valid=(cnt!=0); if_pc/if_instr driven from head regs (registered storage);
//   push+pop same cycle: count unchanged; pop when empty ignored.
//  Throughput: i_cache hit -> one instruction every 2 cycles; miss latency passes through.
//  fetch_en=0 blocks new issue only; in-flight response still pushed.
// TESTING
//  1 RESET_PC=0x100, fetch_en=1, ic_ready+ic_rdata=0xDEADBEEF 1 cycle after ic_rd ->
//    one-cycle ic_rd, ic_addr=0x100, then if_valid, if_pc=0x100, if_instr=0xDEADBEEF;
//    next ic_rd at 0x104.
//  2 ic_ready delayed 10 cycles -> ic_addr stays 0x104, ic_rd low all 10 cycles, one push.
//  3 if_ready=0, FIFO_DEPTH=4 -> exactly 4 pushes (0x100..0x10C), no 5th ic_rd; if_ready=1
//    -> pops in order, fetching resumes at 0x110.
//  4 redirect_pc=0x203 during WAIT -> ic_addr held until ic_ready, data dropped, FIFO
//    empty, next ic_rd with ic_addr=0x200.
//  5 redirect_valid, ic_ready and pop in same cycle -> count 0, nothing pushed, next
//    ic_addr=redirect target.
//  6 rst_n low mid-miss -> ic_rd=0, if_valid=0, ic_addr=RESET_PC immediately (async);
//    after release, clean fetch from RESET_PC (i_cache reset together).

Source files
------------

// File: rtl/fetch_unit_if.sv
// ------------------------------------------------------------------
// fetch_unit_if: i_cache CPU-side port and decode valid/ready port
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ic_addr;
  logic                  ic_rd;
  logic [DATA_WIDTH-1:0] ic_rdata;
  logic                  ic_ready;
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [DATA_WIDTH-1:0] if_instr;
  logic                  if_ready;

  modport master (
    output ic_addr, ic_rd, if_valid, if_pc, if_instr,
    input  ic_rdata, ic_ready, if_ready
  );

  modport slave (
    input  ic_addr, ic_rd, if_valid, if_pc, if_instr,
    output ic_rdata, ic_ready, if_ready
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ------------------------------------------------------------------
// fetch_unit: PC owner, single-outstanding i_cache fetch, {pc,instr} FIFO
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_unit_if.master          bus,
  output logic                  fetch_busy
);

  localparam int              PW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_C = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_KILL} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic [ADDR_WIDTH-1:0] req_addr, req_addr_next;
  logic                  req_rd, req_rd_next;

  logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt, cnt_next;
  logic                  push, pop, space;
  logic [ADDR_WIDTH-1:0] seq_pc;

  assign pop     = (cnt != '0) && bus.if_ready;
  assign push    = (state == S_WAIT) && bus.ic_ready && !redirect_valid;
  assign cnt_next = cnt + CW'(push) - CW'(pop);
  // Issuing only when the post-edge count has room guarantees the response a slot.
  assign space   = cnt_next < DEPTH_C;
  assign seq_pc  = req_addr + STEP_C;

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    req_rd_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_en && space && !redirect_valid) begin
          state_next    = S_REQ;
          req_addr_next = pc;
          req_rd_next   = 1'b1;
        end
      end
      S_REQ: begin
        state_next = redirect_valid ? S_KILL : S_WAIT;
      end
      S_WAIT: begin
        if (bus.ic_ready) begin
          state_next = S_IDLE;
          if (!redirect_valid) begin
            pc_next = seq_pc;
            if (fetch_en && space) begin
              state_next    = S_REQ;
              req_addr_next = seq_pc;
              req_rd_next   = 1'b1;
            end
          end
        end else if (redirect_valid) begin
          state_next = S_KILL;
        end
      end
      S_KILL: begin
        if (bus.ic_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (redirect_valid) pc_next = redirect_pc & ALIGN_C;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      req_rd   <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req_addr <= req_addr_next;
      req_rd   <= req_rd_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= req_addr;
        instr_mem[wr_ptr] <= bus.ic_rdata;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt_next;
    end
  end

  assign bus.ic_addr  = req_addr;
  assign bus.ic_rd    = req_rd;
  assign bus.if_valid = (cnt != '0);
  assign bus.if_pc    = pc_mem[rd_ptr];
  assign bus.if_instr = instr_mem[rd_ptr];
  assign fetch_busy   = (state != S_IDLE);

endmodule

`default_nettype wire
